// File: rtl/dma_bus_master.sv
// DMA initiator for the shared system bus: requests the bus from the CPU and moves
// Count words, each as one read cycle from the source followed by one write cycle to the destination.
module dma_bus_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Start,
   input  logic [ADDR_W-1:0] Src_Addr,
   input  logic [ADDR_W-1:0] Dst_Addr,
   input  logic [CNT_W-1:0]  Count,
   input  logic              Src_Inc,
   input  logic              Dst_Inc,
   input  logic              Bus_Grant,
   output logic              Bus_Request,
   output logic [ADDR_W-1:0] address_Bus,
   inout  wire  [DATA_W-1:0] Data_Bus,
   output logic              Read_DMA,
   output logic              Write_DMA,
   output logic              Busy,
   output logic              Done,
   output logic [CNT_W-1:0]  Words_Done
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_RD_ADDR = 3'd2,
      ST_RD_DATA = 3'd3,
      ST_WR      = 3'd4,
      ST_NEXT    = 3'd5,
      ST_FIN     = 3'd6
   } state_t;

   state_t              state_r;
   state_t              state_s;

   logic [ADDR_W-1:0]   src_r;
   logic [ADDR_W-1:0]   dst_r;
   logic [CNT_W-1:0]    count_r;
   logic                src_inc_r;
   logic                dst_inc_r;
   logic [DATA_W-1:0]   word_r;
   logic [CNT_W-1:0]    words_done_r;

   logic                bus_request_r;
   logic                read_dma_r;
   logic                write_dma_r;
   logic                busy_r;
   logic                done_r;
   logic                addr_oe_r;
   logic                data_oe_r;
   logic [ADDR_W-1:0]   addr_r;

   logic                bus_request_s;
   logic                read_dma_s;
   logic                write_dma_s;
   logic                busy_s;
   logic                done_s;
   logic                addr_oe_s;
   logic                data_oe_s;
   logic [ADDR_W-1:0]   addr_s;

   logic                start_accept_s;

   assign start_accept_s = (state_r == ST_IDLE) && Start;

   // Next-state logic; bus grant is only looked at in REQ and NEXT.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (Start) begin
               if (Count == {CNT_W{1'b0}}) begin
                  state_s = ST_FIN;
               end else begin
                  state_s = ST_REQ;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (Bus_Grant) begin
               state_s = ST_RD_ADDR;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_RD_ADDR: state_s = ST_RD_DATA;
         ST_RD_DATA: state_s = ST_WR;
         ST_WR:      state_s = ST_NEXT;
         ST_NEXT: begin
            if (words_done_r == count_r) begin
               state_s = ST_FIN;
            end else if (!Bus_Grant) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_RD_ADDR;
            end
         end
         ST_FIN:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Output decode of the upcoming state so every bus output comes straight from a flop.
   // src/dst only move at the WR closing edge, which never leads into a state that drives them.
   always_comb begin
      bus_request_s = 1'b0;
      read_dma_s    = 1'b0;
      write_dma_s   = 1'b0;
      busy_s        = 1'b0;
      done_s        = 1'b0;
      addr_oe_s     = 1'b0;
      data_oe_s     = 1'b0;
      addr_s        = src_r;
      case (state_s)
         ST_IDLE: begin
            addr_s = src_r;
         end
         ST_REQ, ST_NEXT: begin
            bus_request_s = 1'b1;
            busy_s        = 1'b1;
         end
         ST_RD_ADDR, ST_RD_DATA: begin
            bus_request_s = 1'b1;
            busy_s        = 1'b1;
            read_dma_s    = 1'b1;
            addr_oe_s     = 1'b1;
            addr_s        = src_r;
         end
         ST_WR: begin
            bus_request_s = 1'b1;
            busy_s        = 1'b1;
            write_dma_s   = 1'b1;
            addr_oe_s     = 1'b1;
            data_oe_s     = 1'b1;
            addr_s        = dst_r;
         end
         ST_FIN: begin
            done_s = 1'b1;
         end
         default: begin
            addr_s = src_r;
         end
      endcase
   end

   // State, job parameters, word latch, progress counter and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r       <= ST_IDLE;
         src_r         <= {ADDR_W{1'b0}};
         dst_r         <= {ADDR_W{1'b0}};
         count_r       <= {CNT_W{1'b0}};
         src_inc_r     <= 1'b0;
         dst_inc_r     <= 1'b0;
         word_r        <= {DATA_W{1'b0}};
         words_done_r  <= {CNT_W{1'b0}};
         bus_request_r <= 1'b0;
         read_dma_r    <= 1'b0;
         write_dma_r   <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         addr_oe_r     <= 1'b0;
         data_oe_r     <= 1'b0;
         addr_r        <= {ADDR_W{1'b0}};
      end else begin
         state_r       <= state_s;
         bus_request_r <= bus_request_s;
         read_dma_r    <= read_dma_s;
         write_dma_r   <= write_dma_s;
         busy_r        <= busy_s;
         done_r        <= done_s;
         addr_oe_r     <= addr_oe_s;
         data_oe_r     <= data_oe_s;
         addr_r        <= addr_s;

         if (start_accept_s) begin
            src_r        <= Src_Addr;
            dst_r        <= Dst_Addr;
            count_r      <= Count;
            src_inc_r    <= Src_Inc;
            dst_inc_r    <= Dst_Inc;
            words_done_r <= {CNT_W{1'b0}};
         end

         if (state_r == ST_RD_DATA) begin
            word_r <= Data_Bus;
         end

         if (state_r == ST_WR) begin
            words_done_r <= words_done_r + {{(CNT_W-1){1'b0}}, 1'b1};
            src_r        <= src_r + {{(ADDR_W-1){1'b0}}, src_inc_r};
            dst_r        <= dst_r + {{(ADDR_W-1){1'b0}}, dst_inc_r};
         end
      end
   end

   assign Bus_Request = bus_request_r;
   assign Read_DMA    = read_dma_r;
   assign Write_DMA   = write_dma_r;
   assign Busy        = busy_r;
   assign Done        = done_r;
   assign Words_Done  = words_done_r;
   assign address_Bus = addr_oe_r ? addr_r : {ADDR_W{1'bz}};
   assign Data_Bus    = data_oe_r ? word_r : {DATA_W{1'bz}};

endmodule

// File: tb/tb_dma_bus_master.sv
// Directed bench for dma_bus_master: a 4K-word bus responder model plus a linear sequence of jobs.
module tb_dma_bus_master;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] count;
   logic        src_inc;
   logic        dst_inc;
   logic        bus_grant;
   logic        bus_request;
   logic [31:0] address_bus;
   wire  [31:0] data_bus;
   logic        read_dma;
   logic        write_dma;
   logic        busy;
   logic        done;
   logic [15:0] words_done;

   int checks = 0;
   int errors = 0;

   // bus responder / monitor state
   logic [31:0] mem [0:4095];
   logic [31:0] resp_data = 32'h0000_0000;
   logic        pl_en = 1'b0;
   logic [31:0] pl_addr = 32'h0000_0000;
   logic [31:0] pl_data = 32'h0000_0000;
   int          cyc = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          both_cnt = 0;
   int          ungr_cnt = 0;
   int          done_cnt = 0;
   logic [31:0] rd_log  [0:255];
   logic [31:0] wr_addr_log [0:63];
   logic [31:0] wr_data_log [0:63];
   int          wr_time_log [0:63];

   logic addr_z;
   logic data_z;
   assign addr_z = (address_bus === 32'hzzzz_zzzz);
   assign data_z = (data_bus === 32'hzzzz_zzzz);

   assign data_bus = read_dma ? resp_data : 32'hzzzz_zzzz;

   dma_bus_master #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
      .CLK         (clk),
      .RST         (rst),
      .Start       (start),
      .Src_Addr    (src_addr),
      .Dst_Addr    (dst_addr),
      .Count       (count),
      .Src_Inc     (src_inc),
      .Dst_Inc     (dst_inc),
      .Bus_Grant   (bus_grant),
      .Bus_Request (bus_request),
      .address_Bus (address_bus),
      .Data_Bus    (data_bus),
      .Read_DMA    (read_dma),
      .Write_DMA   (write_dma),
      .Busy        (busy),
      .Done        (done),
      .Words_Done  (words_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Responder latches read data on each read-strobe edge, commits writes, and logs bus activity.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pl_en) mem[pl_addr[11:0]] <= pl_data;
      if (read_dma) begin
         resp_data <= mem[address_bus[11:0]];
         if (rd_cnt < 256) rd_log[rd_cnt] <= address_bus;
         rd_cnt <= rd_cnt + 1;
      end
      if (write_dma) begin
         mem[address_bus[11:0]] <= data_bus;
         if (wr_cnt < 64) begin
            wr_addr_log[wr_cnt] <= address_bus;
            wr_data_log[wr_cnt] <= data_bus;
            wr_time_log[wr_cnt] <= cyc;
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (read_dma && write_dma) both_cnt <= both_cnt + 1;
      if ((read_dma || write_dma) && !bus_grant) ungr_cnt <= ungr_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      tick();
      pl_en   = 1'b0;
   endtask

   task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input logic si, input logic di);
      src_addr = s;
      dst_addr = d;
      count    = n;
      src_inc  = si;
      dst_inc  = di;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, output int n);
      n = 0;
      while (done !== 1'b1 && n < max_cyc) begin
         tick();
         n++;
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req"},   {63'd0, bus_request}, 64'd0);
      check({tag, "_rd"},    {63'd0, read_dma},    64'd0);
      check({tag, "_wr"},    {63'd0, write_dma},   64'd0);
      check({tag, "_busy"},  {63'd0, busy},        64'd0);
      check({tag, "_done"},  {63'd0, done},        64'd0);
      check({tag, "_wdone"}, {48'd0, words_done},  64'd0);
      check({tag, "_addrz"}, {63'd0, addr_z},      64'd1);
      check({tag, "_dataz"}, {63'd0, data_z},      64'd1);
   endtask

   initial begin
      int c0;
      int n;
      int w0;
      int r0;
      int d0;
      int u0;

      rst       = 1'b1;
      start     = 1'b0;
      src_addr  = 32'h0000_0000;
      dst_addr  = 32'h0000_0000;
      count     = 16'd0;
      src_inc   = 1'b0;
      dst_inc   = 1'b0;
      bus_grant = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      check_idle_outputs("reset");

      preload(32'd1006, 32'hA5A5_0001);
      preload(32'd2000, 32'h0000_0000);
      for (int i = 0; i < 4; i++) preload(32'd100 + 32'(i), 32'(i + 1));
      preload(32'd200, 32'h0000_0011);
      preload(32'd201, 32'h0000_0022);
      preload(32'd202, 32'h0000_0033);
      for (int i = 0; i < 4; i++) preload(32'd300 + 32'(i), 32'h30 + 32'(i));
      preload(32'd500, 32'h0000_0000);
      preload(32'd501, 32'h5555_5555);
      preload(32'd400, 32'h0000_0040);
      preload(32'd401, 32'h0000_0041);
      preload(32'd800, 32'h0000_0080);
      preload(32'd900, 32'h9999_9999);
      preload(32'd4095, 32'hDEAD_0001);
      preload(32'd0, 32'hDEAD_0002);

      // T1: single word from fixed IO address, grant tied high
      bus_grant = 1'b1;
      w0 = wr_cnt;
      start_job(32'd1006, 32'd2000, 16'd1, 1'b0, 1'b1);
      c0 = cyc;
      check("t1_busy", {63'd0, busy}, 64'd1);
      check("t1_req", {63'd0, bus_request}, 64'd1);
      wait_done(20, n);
      check("t1_done_lat", 64'(n), 64'd5);
      check("t1_busy_fin", {63'd0, busy}, 64'd0);
      check("t1_wdone", {48'd0, words_done}, 64'd1);
      check("t1_mem", {32'd0, mem[2000]}, {32'd0, 32'hA5A5_0001});
      check("t1_wr_lat", 64'(wr_time_log[w0] - c0), 64'd3);
      tick();
      check("t1_done_pulse", {63'd0, done}, 64'd0);
      tick();
      check("t1_wdone_hold", {48'd0, words_done}, 64'd1);

      // T2: four words into fixed IO port
      w0 = wr_cnt;
      d0 = done_cnt;
      start_job(32'd100, 32'd1006, 16'd4, 1'b1, 1'b0);
      c0 = cyc;
      wait_done(60, n);
      check("t2_done_lat", 64'(n), 64'd17);
      tick();
      tick();
      check("t2_wr_count", 64'(wr_cnt - w0), 64'd4);
      check("t2_done_once", 64'(done_cnt - d0), 64'd1);
      check("t2_first_wr", 64'(wr_time_log[w0] - c0), 64'd3);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_data%0d", i), {32'd0, wr_data_log[w0 + i]}, 64'(i + 1));
         check($sformatf("t2_addr%0d", i), {32'd0, wr_addr_log[w0 + i]}, 64'd1006);
      end
      for (int i = 1; i < 4; i++)
         check($sformatf("t2_gap%0d", i), 64'(wr_time_log[w0 + i] - wr_time_log[w0 + i - 1]), 64'd4);

      // T3: zero-length job
      r0 = rd_cnt;
      w0 = wr_cnt;
      start_job(32'd100, 32'd2000, 16'd0, 1'b1, 1'b1);
      check("t3_done", {63'd0, done}, 64'd1);
      check("t3_req", {63'd0, bus_request}, 64'd0);
      check("t3_busy", {63'd0, busy}, 64'd0);
      check("t3_wdone", {48'd0, words_done}, 64'd0);
      tick();
      check("t3_done_pulse", {63'd0, done}, 64'd0);
      check("t3_req2", {63'd0, bus_request}, 64'd0);
      check("t3_no_rd", 64'(rd_cnt - r0), 64'd0);
      check("t3_no_wr", 64'(wr_cnt - w0), 64'd0);
      tick();

      // T4: grant withheld at first, then dropped after word 1
      bus_grant = 1'b0;
      u0 = ungr_cnt;
      start_job(32'd200, 32'd600, 16'd3, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t4_req_wait%0d", i), {62'd0, bus_request, read_dma}, 64'd2);
         tick();
      end
      bus_grant = 1'b1;
      repeat (4) tick();
      check("t4_word1", {48'd0, words_done}, 64'd1);
      bus_grant = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t4_req_drop%0d", i), {61'd0, bus_request, read_dma, write_dma}, 64'd4);
         tick();
      end
      bus_grant = 1'b1;
      wait_done(40, n);
      check("t4_done_lat", 64'(n), 64'd9);
      check("t4_ungr", 64'(ungr_cnt - u0), 64'd0);
      check("t4_wdone", {48'd0, words_done}, 64'd3);
      check("t4_mem0", {32'd0, mem[600]}, 64'h11);
      check("t4_mem1", {32'd0, mem[601]}, 64'h22);
      check("t4_mem2", {32'd0, mem[602]}, 64'h33);
      tick();
      tick();

      // T5: reset during RD_DATA of word 2
      start_job(32'd300, 32'd500, 16'd4, 1'b1, 1'b1);
      repeat (6) tick();
      check("t5_rd_w2", {63'd0, read_dma}, 64'd1);
      check("t5_addr_w2", {32'd0, address_bus}, 64'd301);
      rst = 1'b1;
      tick();
      check_idle_outputs("t5_rst");
      rst = 1'b0;
      tick();
      tick();
      check("t5_mem0", {32'd0, mem[500]}, 64'h30);
      check("t5_mem1", {32'd0, mem[501]}, {32'd0, 32'h5555_5555});
      check("t5_idle_req", {63'd0, bus_request}, 64'd0);

      // T6: Start while busy is ignored
      start_job(32'd400, 32'd700, 16'd2, 1'b1, 1'b1);
      tick();
      tick();
      start_job(32'd800, 32'd900, 16'd1, 1'b1, 1'b1);
      check("t6_busy", {63'd0, busy}, 64'd1);
      wait_done(40, n);
      check("t6_done", {63'd0, done}, 64'd1);
      check("t6_wdone", {48'd0, words_done}, 64'd2);
      check("t6_mem0", {32'd0, mem[700]}, 64'h40);
      check("t6_mem1", {32'd0, mem[701]}, 64'h41);
      check("t6_mem_other", {32'd0, mem[900]}, {32'd0, 32'h9999_9999});
      tick();
      tick();

      // T7: source address wraps
      r0 = rd_cnt;
      start_job(32'hFFFF_FFFF, 32'd1000, 16'd2, 1'b1, 1'b1);
      wait_done(40, n);
      check("t7_done", {63'd0, done}, 64'd1);
      check("t7_rd0", {32'd0, rd_log[r0]}, {32'd0, 32'hFFFF_FFFF});
      check("t7_rd1", {32'd0, rd_log[r0 + 2]}, 64'd0);
      check("t7_mem0", {32'd0, mem[1000]}, {32'd0, 32'hDEAD_0001});
      check("t7_mem1", {32'd0, mem[1001]}, {32'd0, 32'hDEAD_0002});
      tick();

      check("strobe_overlap", 64'(both_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
